// File: rtl/lid_fifo_pkg.sv
// Shared types and helpers for the credit-based latency-insensitive channel FIFO.
package lid_fifo_pkg;

  localparam int MIN_FIFO_ADDR = 1;
  localparam int MAX_FIFO_ADDR = 10;

  typedef enum logic {
    RD_NORMAL    = 1'b0,
    RD_SHOWAHEAD = 1'b1
  } read_mode_e;

  // Widest occupancy counter any legal configuration can need.
  typedef logic [MAX_FIFO_ADDR:0] usedw_max_t;

  function automatic int fifo_depth(input int addr);
    return 32'sd1 << addr;
  endfunction

  function automatic int usedw_bits(input int addr);
    return addr + 32'sd1;
  endfunction

  function automatic read_mode_e to_read_mode(input int showahead);
    return (showahead != 32'sd0) ? RD_SHOWAHEAD : RD_NORMAL;
  endfunction

endpackage

// File: rtl/lid_fifo_ram.sv
// Simple dual-port storage array; read port is combinational (show-ahead) or registered (normal).
module lid_fifo_ram
  import lid_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 2,
  parameter string      RAMSTYLE   = "MLAB",
  parameter read_mode_e READ_MODE  = RD_SHOWAHEAD
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_wr_en,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_rd_en,
  input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);

  (* ramstyle = RAMSTYLE *) logic signed [DATA_WIDTH-1:0] r_mem [fifo_depth(ADDR_WIDTH)];

  // Write port; contents are intentionally never cleared.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  generate
    if (READ_MODE == RD_SHOWAHEAD) begin : g_comb_rd
      logic w_unused;
      assign w_unused  = i_rd_en ^ reset;
      assign o_rd_data = r_mem[i_rd_addr];
    end else begin : g_reg_rd
      logic signed [DATA_WIDTH-1:0] r_rd_data;
      // Registered read; holds the last dequeued word between reads.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_rd_data <= '0;
        end else if (i_rd_en) begin
          r_rd_data <= r_mem[i_rd_addr];
        end
      end
      assign o_rd_data = r_rd_data;
    end
  endgenerate

endmodule

// File: rtl/lid_credit_fifo.sv
// Receiver-side channel FIFO returning one credit pulse per accepted dequeue,
// with registered occupancy status and sticky overflow/underflow flags.
module lid_credit_fifo
  import lid_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH  = 16,
  parameter int    FIFO_ADDR   = 2,
  parameter int    SHOWAHEAD   = 1,
  parameter int    ALMOST_FULL = (1 << FIFO_ADDR) - 1,
  parameter string RAMSTYLE    = "MLAB"
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_enq,
  input  logic                         i_deq,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full,
  output logic [FIFO_ADDR:0]           o_usedw,
  output logic                         o_credit,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int         DEPTH     = fifo_depth(FIFO_ADDR);
  localparam read_mode_e READ_MODE = to_read_mode(SHOWAHEAD);

  typedef logic [usedw_bits(FIFO_ADDR)-1:0] usedw_t;
  localparam usedw_t               DEPTH_U = usedw_t'(DEPTH);
  localparam usedw_t               AF_U    = usedw_t'(ALMOST_FULL);
  localparam usedw_t               USED_1  = usedw_t'(1);
  localparam logic [FIFO_ADDR-1:0] PTR_1   = FIFO_ADDR'(1);

  generate
    if (FIFO_ADDR < MIN_FIFO_ADDR || FIFO_ADDR > MAX_FIFO_ADDR) begin : g_bad_addr
      $error("lid_credit_fifo: FIFO_ADDR %0d outside %0d..%0d", FIFO_ADDR, MIN_FIFO_ADDR, MAX_FIFO_ADDR);
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
      $error("lid_credit_fifo: ALMOST_FULL %0d outside 1..%0d", ALMOST_FULL, DEPTH);
    end
  endgenerate

  logic [FIFO_ADDR-1:0]         r_wr_ptr, r_rd_ptr;
  usedw_t                       r_usedw, w_usedw_nxt;
  logic                         r_empty, r_full, r_afull, r_valid, r_credit, r_ovf, r_unf;
  logic                         w_deq_ok, w_enq_ok, w_ovf_evt, w_unf_evt;
  logic signed [DATA_WIDTH-1:0] w_ram_data;

  // A dequeue needs stored data; an enqueue into a full FIFO is legal only alongside a dequeue.
  always_comb begin
    w_deq_ok  = i_deq & ~r_empty;
    w_enq_ok  = i_enq & (~r_full | w_deq_ok);
    w_ovf_evt = i_enq & r_full & ~w_deq_ok;
    w_unf_evt = i_deq & r_empty;
    case ({w_enq_ok, w_deq_ok})
      2'b10:   w_usedw_nxt = r_usedw + USED_1;
      2'b01:   w_usedw_nxt = r_usedw - USED_1;
      default: w_usedw_nxt = r_usedw;
    endcase
  end

  // Pointers, occupancy and all status derived from next-state occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_valid  <= 1'b0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_enq_ok) r_wr_ptr <= r_wr_ptr + PTR_1;
      if (w_deq_ok) r_rd_ptr <= r_rd_ptr + PTR_1;
      r_usedw  <= w_usedw_nxt;
      r_empty  <= (w_usedw_nxt == '0);
      r_full   <= (w_usedw_nxt == DEPTH_U);
      r_afull  <= (w_usedw_nxt >= AF_U);
      r_valid  <= (READ_MODE == RD_SHOWAHEAD) ? (w_usedw_nxt != '0) : w_deq_ok;
      r_credit <= w_deq_ok;
      r_ovf    <= r_ovf | w_ovf_evt;
      r_unf    <= r_unf | w_unf_evt;
    end
  end

  lid_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR),
    .RAMSTYLE   (RAMSTYLE),
    .READ_MODE  (READ_MODE)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_enq_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_data),
    .i_rd_en   (w_deq_ok),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_data)
  );

  // Show-ahead presents zero while empty so stale memory never leaks out.
  assign o_data        = (READ_MODE == RD_SHOWAHEAD && r_empty) ? '0 : w_ram_data;
  assign o_valid       = r_valid;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_afull;
  assign o_usedw       = r_usedw;
  assign o_credit      = r_credit;
  assign o_overflow    = r_ovf;
  assign o_underflow   = r_unf;

endmodule
